// File: rtl/rmw_tbl_rd_sched.sv
// rtl/rmw_tbl_rd_sched.sv - round-robin table read scheduler with tag pool and response routing
// Optional: RMW_TBL_RD_SCHED_HAZARD_EN masks requests whose index is already in flight.
module rmw_tbl_rd_sched #(
   parameter int N_REQ  = 4,
   parameter int N_TAGS = 4,
   parameter int ID_W   = 4,
   parameter int WORD_W = 32,
   localparam int TAG_W = (N_TAGS > 1) ? $clog2(N_TAGS) : 1,
   localparam int OWN_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_vld,
   input  logic [N_REQ*ID_W-1:0]  req_id,
   output logic [N_REQ-1:0]       req_rdy_w,
   output logic                   tbl_rd_r,
   output logic [ID_W-1:0]        tbl_rd_id_r,
   output logic [TAG_W-1:0]       tbl_rd_itag_r,
   input  logic                   tbl_rd_word_vld_r,
   input  logic [WORD_W-1:0]      tbl_rd_word_r,
   input  logic [TAG_W-1:0]       tbl_rd_ctag_r,
   output logic [N_REQ-1:0]       rsp_vld_r,
   output logic [WORD_W-1:0]      rsp_word_r,
   output logic [ID_W-1:0]        rsp_id_r,
   output logic [TAG_W:0]         inflight_r,
   output logic                   err_r
`ifdef RMW_TBL_RD_SCHED_HAZARD_EN
   ,
   output logic                   hazard_stall_r
`endif
);

   localparam logic [TAG_W:0] CNT_ONE = 1;

   logic [N_TAGS-1:0] busy;
   logic [OWN_W-1:0]  owner  [N_TAGS];
   logic [ID_W-1:0]   tag_id [N_TAGS];
   logic [OWN_W-1:0]  rr_ptr;

   logic [N_REQ-1:0]  masked;
   logic [N_REQ-1:0]  eligible;
   logic              tag_avail;
   logic [TAG_W-1:0]  free_tag;
   logic              grant;
   logic [OWN_W-1:0]  grant_idx;
   logic [OWN_W-1:0]  rr_next;
   logic              rsp_ok;

   always_comb begin
      masked = '0;
`ifdef RMW_TBL_RD_SCHED_HAZARD_EN
      for (int i = 0; i < N_REQ; i++)
         for (int t = 0; t < N_TAGS; t++)
            if (req_vld[i] && busy[t] && tag_id[t] == req_id[i*ID_W +: ID_W])
               masked[i] = 1'b1;
`endif
      eligible  = req_vld & ~masked;
      tag_avail = ~&busy;
      free_tag  = '0;
      for (int t = N_TAGS - 1; t >= 0; t--)
         if (!busy[t]) free_tag = TAG_W'(t);
      // descending scan so the requester closest to the pointer wins
      grant     = 1'b0;
      grant_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (eligible[idx]) begin
            grant     = tag_avail;
            grant_idx = OWN_W'(idx);
         end
      end
      req_rdy_w = '0;
      if (grant) req_rdy_w[grant_idx] = 1'b1;
      rr_next = (grant_idx == OWN_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rsp_ok  = tbl_rd_word_vld_r && busy[tbl_rd_ctag_r];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy          <= '0;
         rr_ptr        <= '0;
         for (int t = 0; t < N_TAGS; t++) begin
            owner[t]  <= '0;
            tag_id[t] <= '0;
         end
         tbl_rd_r      <= 1'b0;
         tbl_rd_id_r   <= '0;
         tbl_rd_itag_r <= '0;
         rsp_vld_r     <= '0;
         rsp_word_r    <= '0;
         rsp_id_r      <= '0;
         inflight_r    <= '0;
         err_r         <= 1'b0;
`ifdef RMW_TBL_RD_SCHED_HAZARD_EN
         hazard_stall_r <= 1'b0;
`endif
      end else begin
         tbl_rd_r <= grant;
         if (grant) begin
            tbl_rd_id_r      <= req_id[grant_idx*ID_W +: ID_W];
            tbl_rd_itag_r    <= free_tag;
            busy[free_tag]   <= 1'b1;
            owner[free_tag]  <= grant_idx;
            tag_id[free_tag] <= req_id[grant_idx*ID_W +: ID_W];
            rr_ptr           <= rr_next;
         end
         // the allocated tag is always free, so it never collides with ctag here
         rsp_vld_r <= '0;
         if (rsp_ok) begin
            rsp_vld_r            <= N_REQ'(1) << owner[tbl_rd_ctag_r];
            rsp_word_r           <= tbl_rd_word_r;
            rsp_id_r             <= tag_id[tbl_rd_ctag_r];
            busy[tbl_rd_ctag_r]  <= 1'b0;
         end else if (tbl_rd_word_vld_r) begin
            err_r <= 1'b1;
         end
         case ({grant, rsp_ok})
            2'b10:   inflight_r <= inflight_r + CNT_ONE;
            2'b01:   inflight_r <= inflight_r - CNT_ONE;
            default: inflight_r <= inflight_r;
         endcase
`ifdef RMW_TBL_RD_SCHED_HAZARD_EN
         hazard_stall_r <= |masked;
`endif
      end
   end

endmodule
